uart_tx_periph: RTL and testbench

- Memory-mapped UART transmitter. Acts as a bus responder on the CPU_RV32I data bus, alongside RAM.
- The CPU writes bytes into an internal TX FIFO. A serializer drains the FIFO as 8N1 frames on the tx pin.
- The external address decoder asserts busSel for this block's 16-byte window. The block decodes only busAddr[3:2].

---
 rtl/uart_tx_periph.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: CPU bus writes fill a TX FIFO that a
// bit-timed serializer drains onto the tx pin.
module uart_tx_periph #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busSel,
  input  logic [1:0]  busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        tx,
  output logic        txIrq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q, state_d;
  logic          tx_q, tx_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [15:0]   baud_q, baud_d;
  logic          tx_en_q, tx_en_d;
  logic          irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic       wr, push_req, push_ok, pop;
  logic       fifo_empty, fifo_full, can_pop, bit_end, busy;
  logic [1:0] reg_sel;
  logic       unused_bits;

  assign unused_bits = ^{busAddr[31:4], busAddr[1:0], busWData[31:16]};

  assign reg_sel    = busAddr[3:2];
  assign wr         = busSel && (busWe != '0);
  assign push_req   = wr && (reg_sel == 2'd0);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign can_pop    = tx_en_q && !fifo_empty;
  assign bit_end    = (cnt_q == div_q - 16'd1);
  assign busy       = !fifo_empty || (state_q != S_IDLE);
  // A full FIFO still accepts a push when the serializer pops in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (can_pop) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
          state_d = S_DATA;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end else cnt_d = cnt_q + 16'd1;
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (can_pop) pop = 1'b1;
          else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      sh_d    = mem_q[rd_ptr_q];
      div_d   = baud_q;
      cnt_d   = '0;
      tx_d    = 1'b0;
      state_d = S_START;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d    = ovf_q;
    if (push_req && !push_ok) ovf_d = 1'b1;
    else if (wr && (reg_sel == 2'd1) && busWData[3]) ovf_d = 1'b0;
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    if (wr && (reg_sel == 2'd2)) begin
      tx_en_d  = busWData[0];
      irq_en_d = busWData[1];
    end
    baud_d = baud_q;
    if (wr && (reg_sel == 2'd3))
      baud_d = (busWData[15:0] < 16'd2) ? 16'd2 : busWData[15:0];
  end

  always_comb begin
    busRData = '0;
    if (busSel) begin
      case (reg_sel)
        2'd1:    busRData = {16'h0, 8'(count_q), 4'h0, ovf_q, fifo_empty, fifo_full, busy};
        2'd2:    busRData = {30'h0, irq_en_q, tx_en_q};
        2'd3:    busRData = {16'h0, baud_q};
        default: busRData = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      bit_q    <= '0;
      sh_q     <= '0;
      baud_q   <= DIV_RST;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      baud_q   <= baud_d;
      tx_en_q  <= tx_en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= busWData[7:0];
  end

  assign tx    = tx_q;
  assign txIrq = irq_en_q && fifo_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: expected frames are queued on each
// accepted TXDATA write and a line monitor decodes and checks every frame.
module tb_uart_tx_periph;

  localparam int unsigned DEPTH = 8;

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] div;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        busSel = 1'b0;
  logic [1:0]  busWe = 2'b00;
  logic [31:0] busAddr = '0;
  logic [31:0] busWData = '0;
  logic [31:0] busRData;
  logic        tx;
  logic        txIrq;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned wr_cyc = 0;
  int unsigned frames_seen = 0;
  bit          mon_busy = 1'b0;
  logic [15:0] cur_div = 16'd868;
  frame_t      exp_q[$];
  int unsigned starts[$];

  uart_tx_periph #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(868)) dut (
    .clk(clk), .reset(reset), .busSel(busSel), .busWe(busWe),
    .busAddr(busAddr), .busWData(busWData), .busRData(busRData),
    .tx(tx), .txIrq(txIrq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // All bus tasks start and end at a falling edge.
  task automatic bus_write(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] a;
    a        = $urandom;
    a[3:0]   = off;
    busSel   = 1'b1;
    busWe    = 2'($urandom_range(1, 3));
    busAddr  = a;
    busWData = d;
    @(negedge clk);
    wr_cyc   = cyc;
    busSel   = 1'b0;
    busWe    = 2'b00;
    busAddr  = '0;
    busWData = '0;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] d);
    busSel  = 1'b1;
    busWe   = 2'b00;
    busAddr = {28'h0, off};
    #1 d = busRData;
    @(negedge clk);
    busSel  = 1'b0;
    busAddr = '0;
  endtask

  task automatic read_check(input string name, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(off, d);
    check(name, d, exp);
  endtask

  task automatic set_div(input logic [15:0] v);
    cur_div = (v < 16'd2) ? 16'd2 : v;
    bus_write(4'hC, {16'h0, v});
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back('{data: b, div: cur_div});
  endtask

  task automatic send(input logic [7:0] b);
    push_exp(b);
    bus_write(4'h0, {24'h0, b});
  endtask

  function automatic logic [31:0] status_exp(input int unsigned n, input bit ovf, input bit busy);
    return {16'h0, 8'(n), 4'h0, ovf, (n == 0), (n == DEPTH), busy};
  endfunction

  task automatic wait_drain(input string name);
    int unsigned t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (t >= 3000) begin
      bad++;
      $display("FAIL %s_drain got=%0d_pending exp=0", name, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_defaults(input string tag);
    check({tag, "_tx"}, 32'(tx), 32'd1);
    check({tag, "_irq"}, 32'(txIrq), 32'd0);
    read_check({tag, "_status"}, 4'h4, 32'h4);
    read_check({tag, "_ctrl"}, 4'h8, 32'h0);
    read_check({tag, "_baud"}, 4'hC, 32'd868);
    cur_div = 16'd868;
  endtask

  // Line monitor: each start bit pops one expected frame; every sample of the
  // 10*DIV clocks is compared with the ideal waveform.
  initial begin
    frame_t      e;
    int unsigned errs, d, b, s;
    logic [7:0]  got;
    logic        lvl;
    bit          ab;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 || tx !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_frame got=start_bit exp=idle at_cycle=%0d", cyc);
        while (tx === 1'b0 && reset === 1'b1) @(negedge clk);
        continue;
      end
      e = exp_q.pop_front();
      mon_busy = 1'b1;
      starts.push_back(cyc);
      d = int'(e.div);
      errs = 0;
      got = '0;
      ab = 1'b0;
      for (int n = 0; n < 10 * d; n++) begin
        if (n != 0) @(negedge clk);
        if (reset !== 1'b1) begin
          ab = 1'b1;
          break;
        end
        b = n / d;
        s = n % d;
        lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
        if (tx !== lvl) errs++;
        if (b >= 1 && b <= 8 && s == d / 2) got[b-1] = tx;
      end
      if (ab) exp_q.delete();
      else begin
        total++;
        if (errs != 0 || got !== e.data) begin
          bad++;
          $display("FAIL frame got=%h exp=%h div=%0d bad_samples=%0d", got, e.data, d, errs);
        end
        frames_seen++;
      end
      mon_busy = 1'b0;
    end
  end

  initial begin
    int unsigned f0, k, w0;
    logic [31:0] d;
    repeat (3) @(negedge clk);
    check("rst_hold_tx", 32'(tx), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_defaults("por");

    // BAUDDIV clamp and unselected reads
    set_div(16'd0);
    read_check("baud_clamp0", 4'hC, 32'd2);
    set_div(16'd1);
    read_check("baud_clamp1", 4'hC, 32'd2);
    bus_write(4'h8, 32'h2);
    busAddr = 32'h8;
    #1 check("rdata_unsel", busRData, 32'h0);
    @(negedge clk);
    read_check("txdata_read", 4'h0, 32'h0);
    bus_write(4'h8, 32'h0);

    // Reset mid-frame
    set_div(16'd4);
    bus_write(4'h8, 32'h1);
    send(8'h3C);
    repeat (15) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("rst_mid_tx", 32'(tx), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_defaults("rst_mid");

    // Single byte with latency check
    set_div(16'd4);
    bus_write(4'h8, 32'h1);
    starts.delete();
    f0 = frames_seen;
    send(8'hA5);
    w0 = wr_cyc;
    wait_drain("single");
    check("single_frames", frames_seen - f0, 32'd1);
    if (starts.size() > 0) check("single_latency", starts[0] - w0, 32'd1);
    read_check("single_status", 4'h4, status_exp(0, 0, 0));

    // Back-to-back frames
    starts.delete();
    send(8'h55);
    send(8'h0F);
    wait_drain("b2b");
    check("b2b_count", starts.size(), 32'd2);
    if (starts.size() == 2) check("b2b_gap", starts[1] - starts[0], 32'd40);

    // BAUDDIV change mid-frame only affects the next frame
    starts.delete();
    send(8'hC3);
    repeat (10) @(negedge clk);
    set_div(16'd6);
    send(8'h81);
    wait_drain("divchg");
    if (starts.size() == 2) check("divchg_gap", starts[1] - starts[0], 32'd40);
    else check("divchg_count", starts.size(), 32'd2);
    set_div(16'd4);

    // Overflow with transmitter disabled
    bus_write(4'h8, 32'h0);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (exp_q.size() < DEPTH) push_exp(b);
      bus_write(4'h0, {24'h0, b});
    end
    read_check("ovf_status", 4'h4, status_exp(exp_q.size(), 1, 1));
    bus_write(4'h4, 32'h8);
    read_check("ovf_clear", 4'h4, status_exp(exp_q.size(), 0, 1));

    // Push while full, coinciding with the first pop after enabling
    f0 = frames_seen;
    bus_write(4'h8, 32'h1);
    send(8'h96);
    read_check("full_pop_status", 4'h4, status_exp(DEPTH, 0, 1));
    wait_drain("full_pop");
    check("full_pop_frames", frames_seen - f0, 32'd9);
    read_check("full_pop_end", 4'h4, status_exp(0, 0, 0));

    // Interrupt behaviour
    bus_write(4'h8, 32'h3);
    check("irq_idle", 32'(txIrq), 32'd1);
    send(8'h42);
    check("irq_after_push", 32'(txIrq), 32'd0);
    repeat (20) @(negedge clk);
    check("irq_mid_frame", 32'(txIrq), 32'd0);
    wait_drain("irq");
    check("irq_done", 32'(txIrq), 32'd1);
    bus_write(4'h8, 32'h1);
    check("irq_masked", 32'(txIrq), 32'd0);

    // Disabling mid-frame finishes the current frame and holds the rest
    f0 = frames_seen;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    repeat (10) @(negedge clk);
    bus_write(4'h8, 32'h0);
    repeat (60) @(negedge clk);
    check("dis_frames", frames_seen - f0, 32'd1);
    read_check("dis_status", 4'h4, status_exp(2, 0, 1));
    bus_write(4'h8, 32'h1);
    wait_drain("dis_resume");
    check("dis_resume_frames", frames_seen - f0, 32'd3);

    // Randomized bursts
    for (int r = 0; r < 8; r++) begin
      logic [31:0] ctl;
      set_div(16'($urandom_range(2, 7)));
      ctl = $urandom_range(0, 1) ? 32'h3 : 32'h1;
      bus_write(4'h8, ctl);
      k = $urandom_range(1, 6);
      f0 = frames_seen;
      for (int j = 0; j < int'(k); j++) begin
        send(8'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain("rand");
      check("rand_frames", frames_seen - f0, k);
      bus_read(4'h4, d);
      check("rand_status", d, status_exp(0, 0, 0));
      check("rand_irq", 32'(txIrq), {31'h0, ctl[1]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
